// File: rtl/srsw_read_streamer_if.sv
// Command, memory read port and output stream bundle for srsw_read_streamer.
// The out_last flag exists only when SRSW_RSTREAM_LAST_EN is defined.
interface srsw_read_streamer_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;
`ifdef SRSW_RSTREAM_LAST_EN
    logic              out_last;
`endif

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
        output cmd_ready, mem_ren, mem_raddr, out_valid, out_data, busy
`ifdef SRSW_RSTREAM_LAST_EN
        , output out_last
`endif
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, mem_rdata, out_ready,
        input  cmd_ready, mem_ren, mem_raddr, out_valid, out_data, busy
`ifdef SRSW_RSTREAM_LAST_EN
        , input out_last
`endif
    );
endinterface

// File: rtl/srsw_read_streamer.sv
// Burst read sequencer for a 1-cycle-latency memory; SRSW_RSTREAM_LAST_EN adds out_last.
// Latency: command accept to first out_valid is 3 cycles, then one word per cycle.
// Backpressure: 2-entry buffer with credit check on issue; stalls mem_ren, never drops a word.
module srsw_read_streamer #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    srsw_read_streamer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic              inflight_q;
    logic [DATA_W-1:0] buf_q [2];
    logic [1:0]        occ_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic              issue, pop, cap, cmd_ready_c, busy_c, credit_ok;
    logic [2:0]        credit_used;

    assign pop         = (occ_q != 2'd0) & bus.out_ready;
    assign cap         = inflight_q;
    assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
    // Words already buffered or in flight, less the one leaving now, must leave a free slot.
    assign credit_ok   = credit_used < (3'd2 + {2'b00, pop});

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        issue       = 1'b0;
        cmd_ready_c = 1'b0;
        busy_c      = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready_c = 1'b1;
                busy_c      = 1'b0;
                if (bus.cmd_valid) begin
                    addr_d   = bus.cmd_addr;
                    remain_d = bus.cmd_len;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue    = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    remain_d = remain_q - ADDR_W'(1);
                    if (remain_q == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= issue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            occ_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (cap) begin
                buf_q[wr_ptr_q] <= bus.mem_rdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({cap, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

`ifdef SRSW_RSTREAM_LAST_EN
    logic lbuf_q [2];
    logic last_inflight_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_inflight_q <= 1'b0;
            lbuf_q[0]       <= 1'b0;
            lbuf_q[1]       <= 1'b0;
        end else begin
            last_inflight_q <= issue & (remain_q == '0);
            if (cap) begin
                lbuf_q[wr_ptr_q] <= last_inflight_q;
            end
        end
    end

    assign bus.out_last = lbuf_q[rd_ptr_q] & (occ_q != 2'd0);
`endif

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.busy      = busy_c;
    assign bus.mem_ren   = issue;
    assign bus.mem_raddr = addr_q;
    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_data  = buf_q[rd_ptr_q];
endmodule

// File: tb/tb_srsw_read_streamer.sv
// Scoreboard bench: burst model queues expected words/addresses, a negedge monitor checks them.
module tb_srsw_read_streamer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    int   rmode;
    int   pc;
    int   issue_total;
    int   outstanding;
    int   first_valid_cyc;
    int   last_pop_cyc;
    logic prev_stall;
    logic [31:0] prev_data;
    logic [31:0] mem [4];

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;
    exp_t exp_q [$];
    int   addr_exp_q [$];

    srsw_read_streamer_if #(.ADDR_W(2), .DATA_W(32)) bus ();

    srsw_read_streamer #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Registered-read memory: output holds between reads.
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_raddr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        pc = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: bus.out_ready = 1'b1;
                1: begin
                    case (pc % 4)
                        0: bus.out_ready = 1'b1;
                        1: bus.out_ready = 1'b0;
                        2: bus.out_ready = 1'b0;
                        default: bus.out_ready = 1'b1;
                    endcase
                    pc++;
                end
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
        end
    end

    initial begin
        prev_stall  = 1'b0;
        prev_data   = '0;
        issue_total = 0;
        outstanding = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall  = 1'b0;
                outstanding = 0;
            end else begin
                if (bus.mem_ren) begin
                    issue_total++;
                    outstanding++;
                    if (addr_exp_q.size() == 0) chk("unexpected_mem_ren", 64'd1, 64'd0);
                    else chk("mem_raddr", {62'd0, bus.mem_raddr}, 64'(addr_exp_q.pop_front()));
                end
                if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (prev_stall) begin
                    chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
                    chk("stall_data", {32'd0, bus.out_data}, {32'd0, prev_data});
                end
                if (bus.out_valid && exp_q.size() == 0) begin
                    chk("unexpected_word", {32'd0, bus.out_data}, 64'hdead_0000_0000);
                end else if (bus.out_valid && bus.out_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
`ifdef SRSW_RSTREAM_LAST_EN
                    chk("out_last", {63'd0, bus.out_last}, {63'd0, e.last});
`endif
                    last_pop_cyc = cyc;
                end
                if (bus.out_valid && bus.out_ready) outstanding--;
                if (outstanding > 2) chk("buffered_le_2", 64'(outstanding), 64'd2);
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    task automatic send_cmd(input int a, input int l, output int t_acc);
        bit ok;
        ok    = 1'b0;
        t_acc = -1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 2'(a);
        bus.cmd_len   = 2'(l);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok    = 1'b1;
                t_acc = cyc;
                first_valid_cyc = -1;
                for (int k = 0; k <= l; k++) begin
                    int ad;
                    ad = (a + k) % 4;
                    exp_q.push_back('{data: mem[ad], last: (k == l)});
                    addr_exp_q.push_back(ad);
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("cmd_accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(output int t_idle);
        bit ok;
        ok     = 1'b0;
        t_idle = -1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok     = 1'b1;
                t_idle = cyc;
            end
        end
        if (!ok) chk("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic burst(input int a, input int l, input bit timing);
        int t, ti, snap;
        send_cmd(a, l, t);
        snap = issue_total;
        if (timing) begin
            chk("cmd_ready_in_run", {63'd0, bus.cmd_ready}, 64'd0);
            chk("busy_in_run", {63'd0, bus.busy}, 64'd1);
        end
        wait_idle(ti);
        chk("burst_issue_count", 64'(issue_total - snap), 64'(l + 1));
        chk("busy_idle", {63'd0, bus.busy}, 64'd0);
        if (timing) begin
            chk("first_valid_latency", 64'(first_valid_cyc - t), 64'd3);
            chk("last_pop_cycle", 64'(last_pop_cyc - t), 64'(l + 3));
            chk("idle_cycle", 64'(ti - t), 64'(l + 4));
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", {63'd0, bus.cmd_ready}, 64'd1);
        chk("rst_mem_ren", {63'd0, bus.mem_ren}, 64'd0);
        chk("rst_mem_raddr", {62'd0, bus.mem_raddr}, 64'd0);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
`ifdef SRSW_RSTREAM_LAST_EN
        chk("rst_out_last", {63'd0, bus.out_last}, 64'd0);
`endif
    endtask

    initial begin
        int t1, t2, ti, snap;
        bit ok;
        n_cmp = 0;
        n_err = 0;
        rmode = 0;
        first_valid_cyc = -1;
        last_pop_cyc = -1;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        burst(0, 3, 1'b1);
        burst(2, 3, 1'b1);
        rmode = 1;
        burst(0, 3, 1'b0);
        rmode = 0;
        burst(1, 0, 1'b1);

        // Reset in the middle of a burst, once two reads have gone out.
        send_cmd(0, 3, t1);
        snap = issue_total;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (issue_total - snap >= 2) ok = 1'b1;
        end
        if (!ok) chk("mid_burst_issue_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        exp_q.delete();
        addr_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("no_stale_word", {63'd0, bus.out_valid}, 64'd0);
        burst(3, 0, 1'b1);

        // Second command held while the first burst runs.
        send_cmd(0, 3, t1);
        send_cmd(2, 1, t2);
        chk("held_cmd_accept_cycle", 64'(t2 - t1), 64'd7);
        wait_idle(ti);
        chk("held_cmd_idle_cycle", 64'(ti - t2), 64'd5);

        rmode = 2;
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) mem[k] = $urandom;
            burst($urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end
        rmode = 0;
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("addr_queue_empty", 64'(addr_exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/srsw_read_streamer.md
# srsw_read_streamer

Read-side sequencer that drives the read port of a single-read/single-write memory with registered read data (one-cycle read latency, output register holds its value between reads). Accepts burst read commands (start address, length) on a valid/ready channel, issues one read per cycle, captures returning words into a 2-entry buffer, and presents them as a valid/ready stream to the downstream consumer. Backpressure never loses or duplicates a word; the block is pause-safe because all state advances only on `clk`.

## Interface
- `ADDR_W`, 2, memory address width; depth = 2^ADDR_W words
- `DATA_W`, 32, memory and stream data width
- `clk`  in  1  sole clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_addr`  in  ADDR_W  first word address
- `cmd_len`  in  ADDR_W  words to read minus one (0 -> 1 word, 3 -> 4 words)
- `mem_ren`  out  1  memory read enable
- `mem_raddr`  out  ADDR_W  memory read address
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_ren`
- `out_valid`  out  1  stream word available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  DATA_W  stream word
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE: `cmd_ready`=1. On handshake: load `addr`<=`cmd_addr`, `remain`<=`cmd_len`; -> RUN.
- RUN: `mem_ren`=1 when `occ + inflight - pop < 2` (`occ` = buffer count, `inflight` = 1 if `mem_ren` was high last cycle, `pop` = `out_valid & out_ready` this cycle). Each issue: `addr`<=`addr+1` mod 2^ADDR_W (wraps 3->0 at ADDR_W=2), `remain`<=`remain-1`. Issue with `remain`==0 -> DRAIN.
- DRAIN: no issues; -> IDLE in the cycle where `inflight`=0, `occ`=0 (or `occ`=1 and `pop`). `cmd_ready`=0 in RUN and DRAIN.
- Capture: when `inflight`=1, `mem_rdata` is written into the buffer tail that cycle. Buffer is FIFO, depth 2; credit rule guarantees no overflow; overflow is a design error.
- `mem_raddr` = `addr` register; holds last value when `mem_ren`=0.
- Simultaneous capture and pop: count unchanged, order preserved.
- `out_data` holds stable while `out_valid & !out_ready`.

## Timing
- Reset values: `cmd_ready`=1, `mem_ren`=0, `mem_raddr`=0, `out_valid`=0, `out_data`=0, `busy`=0; buffer count and inflight cleared.
- Command accepted at edge ending cycle T -> `mem_ren` high in T+1 -> `mem_rdata` valid T+2 -> `out_valid` high T+3.
- With `out_ready` held 1: one word per cycle; burst of N words finishes (last pop) at T+2+N; IDLE (`cmd_ready`=1) in T+3+N.
- `rst_n` low mid-burst: immediate clear of all state; in-flight read data ignored; no word emitted after release until a new command.
- Back-to-back commands: the next command is accepted only in IDLE (one idle cycle minimum between bursts).

## Configuration
- `SRSW_RSTREAM_LAST_EN`: defined -> adds output port `out_last` (1 bit), high with the final word of each burst; buffer carries the flag per entry; reset value 0. Undefined -> port absent, no flag storage; all other behaviour identical.

## Test plan
- Preload mem[0..3]=0x11,0x22,0x33,0x44; cmd addr=0 len=3, `out_ready`=1 -> stream 0x11,0x22,0x33,0x44 on consecutive cycles, first `out_valid` 3 cycles after accept, `busy` falls after last pop.
- Wrap: cmd addr=2 len=3 -> `mem_raddr` 2,3,0,1; stream 0x33,0x44,0x11,0x22 (`out_last` only on 0x22 if macro defined).
- Backpressure: `out_ready` toggled 1,0,0,1,... during 4-word burst -> no more than 2 buffered, `mem_ren` stalls, words in order, no duplicates, `out_data` stable while stalled.
- Single word: cmd addr=1 len=0 -> exactly one `mem_ren` cycle, one word 0x22, `cmd_ready` back after 4 cycles.
- Reset mid-burst: assert `rst_n`=0 after second word issued -> outputs at reset values same cycle; after release, no stale word; new cmd addr=3 len=0 returns 0x44.
- Command while busy: hold `cmd_valid` during a burst -> `cmd_ready`=0 until IDLE, then accepted, executed with its own addr/len.
